// File: rtl/clock_pkg.sv
// Shared constants, payload types and digit-validity helpers for the BCD alarm clock.
package clock_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CHAR_W  = 8;

    localparam logic [2:0] SEL_SEC_L  = 3'd0;
    localparam logic [2:0] SEL_SEC_H  = 3'd1;
    localparam logic [2:0] SEL_MIN_L  = 3'd2;
    localparam logic [2:0] SEL_MIN_H  = 3'd3;
    localparam logic [2:0] SEL_HOUR_L = 3'd4;
    localparam logic [2:0] SEL_HOUR_H = 3'd5;

    localparam logic [CHAR_W-1:0]  ASCII_ZERO   = 8'h30;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;
    localparam logic [DIGIT_W-1:0] TENS_MAX     = 4'd5;
    localparam logic [DIGIT_W-1:0] HOUR_H_MAX   = 4'd2;
    localparam logic [DIGIT_W-1:0] HOUR_L_MAX_2X = 4'd3;

    typedef struct packed {
        logic [DIGIT_W-1:0] hour_h;
        logic [DIGIT_W-1:0] hour_l;
        logic [DIGIT_W-1:0] min_h;
        logic [DIGIT_W-1:0] min_l;
        logic [DIGIT_W-1:0] sec_h;
        logic [DIGIT_W-1:0] sec_l;
    } time_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] hour_h;
        logic [DIGIT_W-1:0] hour_l;
        logic [DIGIT_W-1:0] min_h;
        logic [DIGIT_W-1:0] min_l;
    } alarm_t;

    // True when h_hi:h_lo forms an hour in 00..23.
    function automatic logic hour_valid(input logic [DIGIT_W-1:0] h_hi,
                                        input logic [DIGIT_W-1:0] h_lo);
        return (h_lo <= DIGIT_MAX) &&
               ((h_hi < HOUR_H_MAX) || ((h_hi == HOUR_H_MAX) && (h_lo <= HOUR_L_MAX_2X)));
    endfunction

    // True when writing val into digit sel keeps the clock value legal.
    function automatic logic digit_ok(input logic [2:0]         sel,
                                      input logic [DIGIT_W-1:0] val,
                                      input logic [DIGIT_W-1:0] cur_h_hi,
                                      input logic [DIGIT_W-1:0] cur_h_lo);
        case (sel)
            SEL_SEC_L, SEL_MIN_L: return val <= DIGIT_MAX;
            SEL_SEC_H, SEL_MIN_H: return val <= TENS_MAX;
            SEL_HOUR_L:           return hour_valid(cur_h_hi, val);
            SEL_HOUR_H:           return hour_valid(val, cur_h_lo);
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/num2ascii.sv
// BCD digit to ASCII character conversion.
module num2ascii
    import clock_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [CHAR_W-1:0]  chr
);

    assign chr = ASCII_ZERO + CHAR_W'(digit);

endmodule

// File: rtl/rtc_alarm_clock_tick_div.sv
// Clock-enable divider: strobe is high for one cycle every CLK_HZ/TICK_HZ cycles.
module tick_div #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic CLOCK_50,
    input  logic clr,
    input  logic hold,
    output logic strobe
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             at_top;

    assign at_top = (cnt == CNT_W'(DIV - 1));
    assign strobe = at_top && !hold;

    // Held at zero while paused so a full period follows every release.
    always_ff @(posedge CLOCK_50) begin
        if (clr || hold)  cnt <= '0;
        else if (at_top)  cnt <= '0;
        else              cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/rtc_alarm_clock.sv
// BCD hh:mm:ss clock with guarded digit loads, one hh:mm alarm and 12/24-hour ASCII display.
module rtc_alarm_clock
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned TICK_HZ   = 1,
    parameter int unsigned ALARM_LEN = 10
) (
    input  logic                CLOCK_50,
    input  logic                clr,
    input  logic                pause,
    input  logic [2:0]          sel,
    input  logic [DIGIT_W-1:0]  load,
    input  logic                load_en,
    input  logic                alarm_set,
    input  logic                alarm_en,
    input  logic                mode12,
    output logic [6*CHAR_W-1:0] ascii,
    output logic                pm,
    output logic                alarm,
    output logic                tick
);

    localparam int unsigned CD_W = $clog2(ALARM_LEN + 1);

    time_t             cur, nxt, time_d;
    alarm_t            alm, alm_d;
    logic              s;
    logic              match_c;
    logic              time_wr_c, alarm_wr_c;
    logic [CD_W-1:0]   cd;
    logic [4:0]        hour_bin_c, hour12_c;
    logic [DIGIT_W-1:0] disp_hh_c, disp_hl_c;
    logic [DIGIT_W-1:0] disp_digit_c [6];
    logic [CHAR_W-1:0]  disp_chr_c   [6];

    tick_div #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick_div (
        .CLOCK_50 (CLOCK_50),
        .clr      (clr),
        .hold     (pause),
        .strobe   (s)
    );

    // One-second increment with BCD carry chain and 23:59:59 rollover.
    always_comb begin
        nxt = cur;
        if (cur.sec_l != DIGIT_MAX) begin
            nxt.sec_l = cur.sec_l + 4'd1;
        end else begin
            nxt.sec_l = '0;
            if (cur.sec_h != TENS_MAX) begin
                nxt.sec_h = cur.sec_h + 4'd1;
            end else begin
                nxt.sec_h = '0;
                if (cur.min_l != DIGIT_MAX) begin
                    nxt.min_l = cur.min_l + 4'd1;
                end else begin
                    nxt.min_l = '0;
                    if (cur.min_h != TENS_MAX) begin
                        nxt.min_h = cur.min_h + 4'd1;
                    end else begin
                        nxt.min_h = '0;
                        if (cur.hour_h == HOUR_H_MAX && cur.hour_l == HOUR_L_MAX_2X) begin
                            nxt.hour_h = '0;
                            nxt.hour_l = '0;
                        end else if (cur.hour_l == DIGIT_MAX) begin
                            nxt.hour_h = cur.hour_h + 4'd1;
                            nxt.hour_l = '0;
                        end else begin
                            nxt.hour_l = cur.hour_l + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign time_wr_c  = load_en && !alarm_set && pause &&
                        digit_ok(sel, load, cur.hour_h, cur.hour_l);
    assign alarm_wr_c = load_en && alarm_set && (sel >= SEL_MIN_L) &&
                        digit_ok(sel, load, alm.hour_h, alm.hour_l);

    // Next time/alarm register values from tick or accepted digit writes.
    always_comb begin
        time_d = cur;
        alm_d  = alm;
        if (s) begin
            time_d = nxt;
        end else if (time_wr_c) begin
            case (sel)
                SEL_SEC_L:  time_d.sec_l  = load;
                SEL_SEC_H:  time_d.sec_h  = load;
                SEL_MIN_L:  time_d.min_l  = load;
                SEL_MIN_H:  time_d.min_h  = load;
                SEL_HOUR_L: time_d.hour_l = load;
                SEL_HOUR_H: time_d.hour_h = load;
                default:    time_d = cur;
            endcase
        end
        if (alarm_wr_c) begin
            case (sel)
                SEL_MIN_L:  alm_d.min_l  = load;
                SEL_MIN_H:  alm_d.min_h  = load;
                SEL_HOUR_L: alm_d.hour_l = load;
                SEL_HOUR_H: alm_d.hour_h = load;
                default:    alm_d = alm;
            endcase
        end
    end

    assign match_c = (nxt.sec_l == '0) && (nxt.sec_h == '0) &&
                     (nxt.min_l == alm.min_l) && (nxt.min_h == alm.min_h) &&
                     (nxt.hour_l == alm.hour_l) && (nxt.hour_h == alm.hour_h);

    always_ff @(posedge CLOCK_50) begin
        if (clr) begin
            cur  <= '0;
            alm  <= '0;
            tick <= 1'b0;
        end else begin
            cur  <= time_d;
            alm  <= alm_d;
            tick <= s;
        end
    end

    // Alarm countdown: only a tick-driven match fires; alarm_en low clears it.
    always_ff @(posedge CLOCK_50) begin
        if (clr || !alarm_en) begin
            alarm <= 1'b0;
            cd    <= '0;
        end else if (s) begin
            if (match_c) begin
                alarm <= 1'b1;
                cd    <= CD_W'(ALARM_LEN);
            end else if (alarm) begin
                cd <= cd - CD_W'(1);
                if (cd == CD_W'(1)) alarm <= 1'b0;
            end
        end
    end

    // 12-hour display mapping; internal hours stay 24-hour.
    always_comb begin
        hour_bin_c = 5'(cur.hour_h) * 5'd10 + 5'(cur.hour_l);
        hour12_c   = hour_bin_c - 5'd12;
        disp_hh_c  = cur.hour_h;
        disp_hl_c  = cur.hour_l;
        if (mode12) begin
            if (hour_bin_c == 5'd0) begin
                disp_hh_c = 4'd1;
                disp_hl_c = 4'd2;
            end else if (hour_bin_c > 5'd12) begin
                disp_hh_c = (hour12_c >= 5'd10) ? 4'd1 : 4'd0;
                disp_hl_c = (hour12_c >= 5'd10) ? 4'(hour12_c - 5'd10) : 4'(hour12_c);
            end
        end
        disp_digit_c[5] = disp_hh_c;
        disp_digit_c[4] = disp_hl_c;
        disp_digit_c[3] = cur.min_h;
        disp_digit_c[2] = cur.min_l;
        disp_digit_c[1] = cur.sec_h;
        disp_digit_c[0] = cur.sec_l;
    end

    for (genvar i = 0; i < 6; i++) begin : g_chr
        num2ascii u_num2ascii (
            .digit (disp_digit_c[i]),
            .chr   (disp_chr_c[i])
        );
    end

    always_ff @(posedge CLOCK_50) begin
        if (clr) begin
            ascii <= {6{ASCII_ZERO}};
            pm    <= 1'b0;
        end else begin
            ascii <= {disp_chr_c[5], disp_chr_c[4], disp_chr_c[3],
                      disp_chr_c[2], disp_chr_c[1], disp_chr_c[0]};
            pm    <= (hour_bin_c >= 5'd12);
        end
    end

endmodule

// File: tb/tb_rtc_alarm_clock.sv
// Directed bench for rtc_alarm_clock with a 4-cycle tick period and 3-tick alarm.
module tb_rtc_alarm_clock;

    logic        CLOCK_50 = 1'b0;
    logic        clr = 1'b1;
    logic        pause = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [3:0]  load = 4'd0;
    logic        load_en = 1'b0;
    logic        alarm_set = 1'b0;
    logic        alarm_en = 1'b0;
    logic        mode12 = 1'b0;
    logic [47:0] ascii;
    logic        pm;
    logic        alarm;
    logic        tick;

    int checks = 0;
    int failures = 0;
    int n;

    always #5 CLOCK_50 = ~CLOCK_50;

    rtc_alarm_clock #(.CLK_HZ(4), .TICK_HZ(1), .ALARM_LEN(3)) dut (
        .CLOCK_50  (CLOCK_50),
        .clr       (clr),
        .pause     (pause),
        .sel       (sel),
        .load      (load),
        .load_en   (load_en),
        .alarm_set (alarm_set),
        .alarm_en  (alarm_en),
        .mode12    (mode12),
        .ascii     (ascii),
        .pm        (pm),
        .alarm     (alarm),
        .tick      (tick)
    );

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk48(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] s, input logic [3:0] v, input logic as);
        sel       = s;
        load      = v;
        alarm_set = as;
        load_en   = 1'b1;
        step();
        load_en   = 1'b0;
        alarm_set = 1'b0;
    endtask

    task automatic set_time(input logic [3:0] hh, input logic [3:0] hl,
                            input logic [3:0] mh, input logic [3:0] ml,
                            input logic [3:0] sh, input logic [3:0] sl);
        wr(3'd4, 4'd0, 1'b0);
        wr(3'd5, hh, 1'b0);
        wr(3'd4, hl, 1'b0);
        wr(3'd3, mh, 1'b0);
        wr(3'd2, ml, 1'b0);
        wr(3'd1, sh, 1'b0);
        wr(3'd0, sl, 1'b0);
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (tick !== 1'b1 && cycles < 40);
    endtask

    initial begin
        // Power-on reset
        step();
        step();
        clr = 1'b0;
        chk48("reset_ascii", ascii, 48'h303030303030);
        chk1("reset_pm", pm, 1'b0);
        chk1("reset_alarm", alarm, 1'b0);
        chk1("reset_tick", tick, 1'b0);

        // Reset mid-count from 12:34:56
        pause = 1'b1;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        step();
        chk48("preload_123456", ascii, 48'h313233343536);
        pause = 1'b0;
        step();
        step();
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
        chk48("clr_ascii", ascii, 48'h303030303030);
        chk1("clr_pm", pm, 1'b0);
        chk1("clr_alarm", alarm, 1'b0);
        wait_tick(n);
        chkint("clr_first_tick_latency", n, 4);

        // Midnight rollover
        pause = 1'b1;
        set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
        pause = 1'b0;
        wait_tick(n);
        chkint("release_tick_latency", n, 4);
        step();
        chk48("tick_235959", ascii, 48'h323335393539);
        chk1("pm_23h", pm, 1'b1);
        wait_tick(n);
        chkint("tick_period", n, 3);
        step();
        chk48("rollover_000000", ascii, 48'h303030303030);
        chk1("pm_rollover", pm, 1'b0);

        // Guarded loads
        pause = 1'b1;
        wr(3'd5, 4'd2, 1'b0);
        wr(3'd4, 4'd5, 1'b0);
        wr(3'd0, 4'hA, 1'b0);
        wr(3'd1, 4'd6, 1'b0);
        step();
        chk48("rejected_loads", ascii, 48'h323030303030);
        pause = 1'b0;
        wr(3'd0, 4'd5, 1'b0);
        step();
        chk48("unpaused_load_ignored", ascii, 48'h323030303030);
        pause = 1'b1;

        // Alarm at 00:01
        wr(3'd2, 4'd1, 1'b1);
        wr(3'd3, 4'd0, 1'b1);
        wr(3'd4, 4'd0, 1'b1);
        wr(3'd5, 4'd0, 1'b1);
        alarm_en = 1'b1;
        set_time(4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0);
        step();
        chk1("load_match_no_fire", alarm, 1'b0);
        set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd9);
        pause = 1'b0;
        wait_tick(n);
        chk1("alarm_fire", alarm, 1'b1);
        step();
        chk48("alarm_time_000100", ascii, 48'h303030313030);
        wait_tick(n);
        chk1("alarm_tick2", alarm, 1'b1);
        wait_tick(n);
        chk1("alarm_tick3", alarm, 1'b1);
        wait_tick(n);
        chk1("alarm_tick4_off", alarm, 1'b0);

        pause = 1'b1;
        set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd9);
        pause = 1'b0;
        wait_tick(n);
        chk1("alarm_refire", alarm, 1'b1);
        wait_tick(n);
        chk1("alarm_refire_tick2", alarm, 1'b1);
        alarm_en = 1'b0;
        step();
        chk1("alarm_en_clear", alarm, 1'b0);
        alarm_en = 1'b1;
        wait_tick(n);
        chk1("alarm_stays_cleared", alarm, 1'b0);

        // 12-hour display
        pause = 1'b1;
        alarm_en = 1'b0;
        mode12 = 1'b1;
        set_time(4'd1, 4'd3, 4'd0, 4'd5, 4'd0, 4'd0);
        step();
        chk48("m12_13h", ascii, 48'h303130353030);
        chk1("m12_13h_pm", pm, 1'b1);
        set_time(4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0);
        step();
        chk48("m12_12h", ascii, 48'h313230303030);
        chk1("m12_12h_pm", pm, 1'b1);
        set_time(4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 4'd0);
        step();
        chk48("m12_00h", ascii, 48'h313230373030);
        chk1("m12_00h_pm", pm, 1'b0);
        mode12 = 1'b0;
        step();
        chk48("m24_00h", ascii, 48'h303030373030);

        // Pause mid-second
        pause = 1'b0;
        step();
        step();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk1("paused_no_tick", tick, 1'b0);
        end
        chk48("paused_frozen", ascii, 48'h303030373030);
        pause = 1'b0;
        wait_tick(n);
        chkint("resume_tick_latency", n, 4);
        step();
        chk48("resume_000701", ascii, 48'h303030373031);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
